// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/half/word accesses to an internal array with programmable wait states.
// Latency: data phase completes WAIT_STATES+1 cycles after the address phase; ERROR is always 2 cycles.
module ahb_sram_slave #(
    parameter logic [31:0] START_ADDR     = 32'h0,
    parameter logic [31:0] DEPTH_IN_BYTES = 32'h100,
    parameter logic [31:0] END_ADDR       = START_ADDR + DEPTH_IN_BYTES - 32'd1,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    localparam int unsigned WORDS = DEPTH_IN_BYTES / 4;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic [31:0]      addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [31:0]      mem [WORDS];

    logic             accept;
    logic             legal;
    logic             in_range;
    logic             aligned;
    logic [31:0]      haddr_off;
    logic [31:0]      addr_off;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_en;
    logic             unused_bits;

    // HREADY is normally HREADYOUT looped back; gating with our own ready keeps stalls safe either way.
    assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign haddr_off = HADDR - START_ADDR;
    assign in_range  = (haddr_off <= (END_ADDR - START_ADDR));
    assign legal     = in_range & aligned;

    always_comb begin
        aligned = 1'b0;
        case (HSIZE)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~HADDR[0];
            3'd2:    aligned = (HADDR[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign addr_off    = addr_q - START_ADDR;
    assign word_idx    = addr_off[IDX_W+1:2];
    assign unused_bits = ^{HBURST, addr_off[31:IDX_W+2], addr_off[1:0]};

    always_comb begin
        lane_en = 4'b1111;
        case (size_q)
            3'd0:    lane_en = 4'b0001 << addr_q[1:0];
            3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (accept) begin
                    if (!legal) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        HRDATA    = '0;
        case (state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (!write_q) begin
                    HRDATA = mem[word_idx];
                end
            end
            ST_DATA: begin
                if (!write_q) begin
                    HRDATA = mem[word_idx];
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
            end
            ST_ERR2: HRESP = 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (accept && legal) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Storage is deliberately not reset; a reset edge only suppresses the pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && state == ST_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end
endmodule
